motoro3_duty_ramp_ctrl: RTL and testbench
=========================================

# motoro3_duty_ramp_ctrl

Soft-start/soft-stop duty scheduler for the three-phase motor drive. It owns the 12-bit MOS on-time value consumed by the PWM generator and the phase-run enable that gates the commutation enables. Duty changes are sequenced through align, ramp-up, run and ramp-down phases. Updates happen only on commutation ticks (`m3cntLast1`), so the generator always latches a settled value at its own reload boundary.

## Interface
- `DUTY_W`, 12, duty width; matches the generator on-time field.
- `STEP_W`, 8, ramp step width.
- `MIN_DUTY`, 12'h040, align duty and floor for run/ramp.
- `HOLD_TICKS`, 4, commutation ticks spent in ALIGN (≥1).

Ports:
- `clk` in 1: system clock, 10 MHz.
- `nRst` in 1: asynchronous, active-low reset.
- `m3cntLast1` in 1: commutation tick, one-cycle pulse.
- `startReq` in 1: level or pulse; start motor.
- `stopReq` in 1: level or pulse; controlled stop.
- `faultIn` in 1: over-current/driver fault, level.
- `faultClr` in 1: pulse; leave FAULT.
- `dutyTarget` in DUTY_W: requested run duty.
- `rampStep` in STEP_W: duty change per tick; 0 treated as 1.
- `duty` out DUTY_W: duty to PWM generator.
- `dutyLoad` out 1: one-cycle pulse, the cycle after `duty` changes.
- `runEn` out 1: phase enables allowed; 0 forces aE/bE/cE low upstream.
- `state` out 3: current state code.

## Operation
- States and codes: IDLE=0, ALIGN=1, RAMP_UP=2, RUN=3, RAMP_DOWN=4, FAULT=5. Codes 6–7 recover to FAULT.
- Effective target: `tgt = max(dutyTarget, MIN_DUTY)`, sampled on each tick.
- Event priority each cycle: faultIn > stopReq > startReq > tick.
- IDLE: `duty=0`, `runEn=0`. On startReq with faultIn low, go to ALIGN, `duty=MIN_DUTY`, `runEn=1`, `holdCnt=HOLD_TICKS`.
- ALIGN: each tick decrements `holdCnt`. The tick where `holdCnt==1` enters RAMP_UP; duty stays at MIN_DUTY.
- RAMP_UP: each tick sets `duty = min(duty+step, tgt)` using 13-bit add, saturating at 12'hFFF. Enter RUN on the tick where the result equals tgt.
- RUN: each tick slews toward tgt by at most step in either direction, with no overshoot.
- stopReq in ALIGN, RAMP_UP or RUN enters RAMP_DOWN. It is ignored in IDLE, RAMP_DOWN and FAULT.
- RAMP_DOWN: each tick, if `duty - step ≤ MIN_DUTY` (compared unsigned, no wrap), set `duty=0`, `runEn=0` and go to IDLE. Otherwise `duty -= step`.
- startReq during RAMP_DOWN is ignored; a new start requires IDLE.
- faultIn high in any state: next cycle `duty=0`, `runEn=0`, state FAULT.
- FAULT exits to IDLE only on faultClr with faultIn low. startReq is ignored in FAULT.
- `dutyLoad` asserts for exactly one cycle after any cycle in which the `duty` register changed value.

## Timing
- Reset values: `duty=0`, `runEn=0`, `dutyLoad=0`, `state=IDLE`, `holdCnt=0`.
- All outputs are registered.
- Latency, input to `duty`/`state`: tick → 1 cycle; start/fault → 1 cycle.
- `dutyLoad` follows `duty` by 1 cycle.
- The generator latches its on-time on `m3cntLast1`, so a duty computed on tick N takes effect at tick N+1.
- Simultaneous faultIn and tick: fault wins, and no slew is applied.
- Simultaneous stopReq and tick in RUN: enter RAMP_DOWN with duty unchanged that cycle.
- Reset asserted mid-ramp: immediate return to reset values; no ramp-down.

## Structure
- Shared package `motoro3_pkg` holds:
  - state encoding constants;
  - `DUTY_W`;
  - default `MIN_DUTY` and `HOLD_TICKS`;
  - `DUTY_FULL` = 12'hFFF.
- One combinational sub-module, `motoro3_slew_sat`.
  - Inputs: current, target, step.
  - Output: next duty, with saturating up/down step and clamping at target.
  - Used by RAMP_UP and RUN.

## Test plan
Unless stated otherwise, tests use MIN_DUTY=0x040, HOLD_TICKS=4, step=0x40.

- **Reset:** assert nRst low mid-RUN → `duty=0`, `runEn=0`, `dutyLoad=0`, `state=0` asynchronously.
- **Start:** startReq, target 0x100 → next cycle `duty=0x040`, `state=1`. After 4 ticks, state 2. The following ticks give 0x080, 0x0C0, 0x100, with state 3 on the 0x100 tick. `dutyLoad` pulses after each change.
- **Run retarget:** RUN at 0x100, target 0x0D0 → 0x0D0 in one tick, no undershoot. Target 0x000 → tgt clamps to 0x040.
- **Stop:** RUN at 0x100 with stopReq → ticks give 0x0C0, 0x080, then 0 with `runEn=0`, state IDLE.
- **Fault:** faultIn asserted during RAMP_UP coincident with a tick → next cycle `duty=0`, state 5. startReq is ignored. faultClr while faultIn high → stays FAULT. faultClr while faultIn low → IDLE.
- **Saturation:** RUN at 0xF80, target 0xFFF, step 0xFF → 0xFFF with no wrap. rampStep=0 → duty moves by 1 per tick.

Source files
------------

// File: rtl/motoro3_pkg.sv
// Shared constants and state encoding for the motor-drive duty scheduler.
// DUTY_W is fixed by the PWM generator's on-time field.
package motoro3_pkg;

   localparam int                DUTY_W         = 12;
   localparam int                STEP_W_DEF     = 8;
   localparam logic [DUTY_W-1:0] MIN_DUTY_DEF   = 12'h040;
   localparam int                HOLD_TICKS_DEF = 4;
   localparam logic [DUTY_W-1:0] DUTY_FULL      = 12'hFFF;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ALIGN     = 3'd1,
      ST_RAMP_UP   = 3'd2,
      ST_RUN       = 3'd3,
      ST_RAMP_DOWN = 3'd4,
      ST_FAULT     = 3'd5
   } state_e;

endpackage

// File: rtl/motoro3_slew_sat.sv
// Combinational duty slew: saturating step toward a target, never crossing it.
// o_up is the upward-only form; o_slew moves in whichever direction is needed.
module motoro3_slew_sat
   import motoro3_pkg::*;
#(
   parameter int STEP_W = STEP_W_DEF
) (
   input  logic [DUTY_W-1:0] i_cur,
   input  logic [DUTY_W-1:0] i_tgt,
   input  logic [STEP_W-1:0] i_step,
   output logic [DUTY_W-1:0] o_up,
   output logic [DUTY_W-1:0] o_slew
);

   logic [DUTY_W-1:0] w_step_ext;
   logic [DUTY_W:0]   w_sum;
   logic [DUTY_W-1:0] w_sum_sat;
   logic [DUTY_W-1:0] w_gap;
   logic [DUTY_W-1:0] w_dn;

   assign w_step_ext = {{(DUTY_W-STEP_W){1'b0}}, i_step};
   assign w_sum      = {1'b0, i_cur} + {1'b0, w_step_ext};
   assign w_sum_sat  = w_sum[DUTY_W] ? DUTY_FULL : w_sum[DUTY_W-1:0];
   assign o_up       = (w_sum_sat > i_tgt) ? i_tgt : w_sum_sat;

   // Only meaningful when i_cur > i_tgt; the gap test prevents undershoot.
   assign w_gap  = i_cur - i_tgt;
   assign w_dn   = (w_gap <= w_step_ext) ? i_tgt : (i_cur - w_step_ext);
   assign o_slew = (i_cur <= i_tgt) ? o_up : w_dn;

endmodule

// File: rtl/motoro3_duty_ramp_ctrl.sv
// Soft-start/soft-stop duty scheduler for the three-phase drive; duty only
// moves on commutation ticks so the PWM generator latches settled values.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | motor off, duty 0, phase enables blocked
//   ALIGN      | rotor alignment at MIN_DUTY for HOLD_TICKS ticks
//   RAMP_UP    | duty climbs by step per tick until it reaches target
//   RUN        | duty tracks target, at most one step per tick
//   RAMP_DOWN  | duty falls by step per tick, then drive shuts off
//   FAULT      | drive off until faultClr with faultIn released
module motoro3_duty_ramp_ctrl
   import motoro3_pkg::*;
#(
   parameter int                STEP_W     = STEP_W_DEF,
   parameter logic [DUTY_W-1:0] MIN_DUTY   = MIN_DUTY_DEF,
   parameter int                HOLD_TICKS = HOLD_TICKS_DEF
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              m3cntLast1,
   input  logic              startReq,
   input  logic              stopReq,
   input  logic              faultIn,
   input  logic              faultClr,
   input  logic [DUTY_W-1:0] dutyTarget,
   input  logic [STEP_W-1:0] rampStep,
   output logic [DUTY_W-1:0] duty,
   output logic              dutyLoad,
   output logic              runEn,
   output logic [2:0]        state
);

   localparam int HOLD_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [DUTY_W-1:0] r_duty;
   logic [DUTY_W-1:0] w_duty_nxt;
   logic              r_run;
   logic              w_run_nxt;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic              r_chg;
   logic              r_load;

   logic [DUTY_W-1:0] w_tgt;
   logic [STEP_W-1:0] w_step;
   logic [DUTY_W-1:0] w_up;
   logic [DUTY_W-1:0] w_slew;
   logic [DUTY_W:0]   w_floor;
   logic              w_dn_done;
   logic [DUTY_W-1:0] w_dn;

   assign w_tgt  = (dutyTarget < MIN_DUTY) ? MIN_DUTY : dutyTarget;
   assign w_step = (rampStep == '0) ? {{(STEP_W-1){1'b0}}, 1'b1} : rampStep;

   motoro3_slew_sat #(
      .STEP_W (STEP_W)
   ) u_slew (
      .i_cur  (r_duty),
      .i_tgt  (w_tgt),
      .i_step (w_step),
      .o_up   (w_up),
      .o_slew (w_slew)
   );

   // duty - step <= MIN_DUTY, rearranged so nothing can wrap below zero.
   assign w_floor   = {1'b0, MIN_DUTY} + {{(DUTY_W+1-STEP_W){1'b0}}, w_step};
   assign w_dn_done = ({1'b0, r_duty} <= w_floor);
   assign w_dn      = r_duty - {{(DUTY_W-STEP_W){1'b0}}, w_step};

   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_run_nxt   = r_run;
      w_hold_nxt  = r_hold;
      if (faultIn) begin
         w_state_nxt = ST_FAULT;
         w_duty_nxt  = '0;
         w_run_nxt   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (startReq) begin
                  w_state_nxt = ST_ALIGN;
                  w_duty_nxt  = MIN_DUTY;
                  w_run_nxt   = 1'b1;
                  w_hold_nxt  = HOLD_W'(HOLD_TICKS);
               end
            end
            ST_ALIGN: begin
               if (stopReq) begin
                  w_state_nxt = ST_RAMP_DOWN;
               end else if (m3cntLast1) begin
                  w_hold_nxt = r_hold - HOLD_W'(1);
                  if (r_hold == HOLD_W'(1)) w_state_nxt = ST_RAMP_UP;
               end
            end
            ST_RAMP_UP: begin
               if (stopReq) begin
                  w_state_nxt = ST_RAMP_DOWN;
               end else if (m3cntLast1) begin
                  w_duty_nxt = w_up;
                  if (w_up == w_tgt) w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (stopReq) begin
                  w_state_nxt = ST_RAMP_DOWN;
               end else if (m3cntLast1) begin
                  w_duty_nxt = w_slew;
               end
            end
            ST_RAMP_DOWN: begin
               if (m3cntLast1) begin
                  if (w_dn_done) begin
                     w_state_nxt = ST_IDLE;
                     w_duty_nxt  = '0;
                     w_run_nxt   = 1'b0;
                  end else begin
                     w_duty_nxt = w_dn;
                  end
               end
            end
            ST_FAULT: begin
               w_duty_nxt = '0;
               w_run_nxt  = 1'b0;
               if (faultClr) w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_FAULT;
               w_duty_nxt  = '0;
               w_run_nxt   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state <= ST_IDLE;
         r_duty  <= '0;
         r_run   <= 1'b0;
         r_hold  <= '0;
         r_chg   <= 1'b0;
         r_load  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_duty  <= w_duty_nxt;
         r_run   <= w_run_nxt;
         r_hold  <= w_hold_nxt;
         r_chg   <= (w_duty_nxt != r_duty);
         r_load  <= r_chg;
      end
   end

   assign duty     = r_duty;
   assign dutyLoad = r_load;
   assign runEn    = r_run;
   assign state    = r_state;

endmodule

// File: tb/tb_motoro3_duty_ramp_ctrl.sv
// Self-checking bench for motoro3_duty_ramp_ctrl: directed vector table,
// hand-written corner sequences, then random traffic against a reference model.
`timescale 1ns/1ps
module tb_motoro3_duty_ramp_ctrl;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        tick = 1'b0;
   logic        startReq = 1'b0;
   logic        stopReq = 1'b0;
   logic        faultIn = 1'b0;
   logic        faultClr = 1'b0;
   logic [11:0] dutyTarget = '0;
   logic [7:0]  rampStep = 8'h40;
   logic [11:0] duty;
   logic        dutyLoad;
   logic        runEn;
   logic [2:0]  state;

   int total = 0;
   int bad   = 0;

   always #50 clk = ~clk;

   motoro3_duty_ramp_ctrl dut (
      .clk        (clk),
      .nRst       (nRst),
      .m3cntLast1 (tick),
      .startReq   (startReq),
      .stopReq    (stopReq),
      .faultIn    (faultIn),
      .faultClr   (faultClr),
      .dutyTarget (dutyTarget),
      .rampStep   (rampStep),
      .duty       (duty),
      .dutyLoad   (dutyLoad),
      .runEn      (runEn),
      .state      (state)
   );

   typedef struct {
      logic st, sp, f, c, tk;
      int   tgt, stp;
      int   e_state, e_duty, e_run, e_load;
   } vec_t;

   vec_t tv[$];

   task automatic v(input logic st, sp, f, c, tk, input int tgt, stp,
                    input int es, ed, er, el);
      vec_t r;
      r.st = st; r.sp = sp; r.f = f; r.c = c; r.tk = tk;
      r.tgt = tgt; r.stp = stp;
      r.e_state = es; r.e_duty = ed; r.e_run = er; r.e_load = el;
      tv.push_back(r);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic st, sp, f, c, tk, input int tgt, stp);
      @(negedge clk);
      startReq   = st;
      stopReq    = sp;
      faultIn    = f;
      faultClr   = c;
      tick       = tk;
      dutyTarget = tgt[11:0];
      rampStep   = stp[7:0];
      @(posedge clk);
      #1;
   endtask

   // Reference model: behaviour written from the scheduling rules directly.
   int m_state, m_duty, m_run, m_hold, m_chg, m_load;

   task automatic m_reset();
      m_state = 0; m_duty = 0; m_run = 0; m_hold = 0; m_chg = 0; m_load = 0;
   endtask

   task automatic m_step(input logic st, sp, f, c, tk, input int tgt, stp);
      int t, s, nd, ns, nr, nh;
      t  = (tgt < 64) ? 64 : tgt;
      s  = (stp == 0) ? 1 : stp;
      nd = m_duty; ns = m_state; nr = m_run; nh = m_hold;
      if (f) begin
         ns = 5; nd = 0; nr = 0;
      end else if (m_state == 0) begin
         if (st) begin ns = 1; nd = 64; nr = 1; nh = 4; end
      end else if (m_state == 1) begin
         if (sp) ns = 4;
         else if (tk) begin
            if (m_hold == 1) ns = 2;
            nh = m_hold - 1;
         end
      end else if (m_state == 2) begin
         if (sp) ns = 4;
         else if (tk) begin
            nd = m_duty + s;
            if (nd > 4095) nd = 4095;
            if (nd > t) nd = t;
            if (nd == t) ns = 3;
         end
      end else if (m_state == 3) begin
         if (sp) ns = 4;
         else if (tk) begin
            if (m_duty < t) nd = (m_duty + s > t) ? t : m_duty + s;
            else            nd = (m_duty - s < t) ? t : m_duty - s;
         end
      end else if (m_state == 4) begin
         if (tk) begin
            if (m_duty - s <= 64) begin nd = 0; nr = 0; ns = 0; end
            else nd = m_duty - s;
         end
      end else begin
         nd = 0; nr = 0;
         if (c) ns = 0;
      end
      m_load  = m_chg;
      m_chg   = (nd != m_duty) ? 1 : 0;
      m_state = ns; m_duty = nd; m_run = nr; m_hold = nh;
   endtask

   task automatic do_reset();
      @(negedge clk);
      nRst = 1'b0;
      startReq = 0; stopReq = 0; faultIn = 0; faultClr = 0; tick = 0;
      dutyTarget = '0; rampStep = 8'h40;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nRst = 1'b1;
      m_reset();
   endtask

   initial begin
      int n;
      logic st, sp, f, c, tk;
      int tgt, stp;

      // Start, run retarget, stop (target 0x100, step 0x40).
      v(1,0,0,0,0, 'h100,'h40, 1,'h040,1,0);
      v(0,0,0,0,0, 'h100,'h40, 1,'h040,1,1);
      v(0,0,0,0,1, 'h100,'h40, 1,'h040,1,0);
      v(0,0,0,0,1, 'h100,'h40, 1,'h040,1,0);
      v(0,0,0,0,1, 'h100,'h40, 1,'h040,1,0);
      v(0,0,0,0,1, 'h100,'h40, 2,'h040,1,0);
      v(0,0,0,0,1, 'h100,'h40, 2,'h080,1,0);
      v(0,0,0,0,0, 'h100,'h40, 2,'h080,1,1);
      v(0,0,0,0,1, 'h100,'h40, 2,'h0C0,1,0);
      v(0,0,0,0,1, 'h100,'h40, 3,'h100,1,1);
      v(0,0,0,0,0, 'h100,'h40, 3,'h100,1,1);
      v(0,0,0,0,0, 'h100,'h40, 3,'h100,1,0);
      v(0,0,0,0,1, 'h0D0,'h40, 3,'h0D0,1,0);
      v(0,0,0,0,1, 'h000,'h40, 3,'h090,1,1);
      v(0,0,0,0,1, 'h000,'h40, 3,'h050,1,1);
      v(0,0,0,0,1, 'h000,'h40, 3,'h040,1,1);
      v(0,0,0,0,1, 'h100,'h40, 3,'h080,1,1);
      v(0,0,0,0,1, 'h100,'h40, 3,'h0C0,1,1);
      v(0,0,0,0,1, 'h100,'h40, 3,'h100,1,1);
      v(0,1,0,0,1, 'h100,'h40, 4,'h100,1,1);
      v(0,0,0,0,1, 'h100,'h40, 4,'h0C0,1,0);
      v(0,0,0,0,1, 'h100,'h40, 4,'h080,1,1);
      v(0,0,0,0,1, 'h100,'h40, 0,'h000,0,1);
      v(0,0,0,0,0, 'h100,'h40, 0,'h000,0,1);
      v(0,0,0,0,0, 'h100,'h40, 0,'h000,0,0);
      // Fault during RAMP_UP coincident with a tick.
      v(1,0,0,0,0, 'h100,'h40, 1,'h040,1,0);
      v(0,0,0,0,1, 'h100,'h40, 1,'h040,1,1);
      v(0,0,0,0,1, 'h100,'h40, 1,'h040,1,0);
      v(0,0,0,0,1, 'h100,'h40, 1,'h040,1,0);
      v(0,0,0,0,1, 'h100,'h40, 2,'h040,1,0);
      v(0,0,0,0,1, 'h100,'h40, 2,'h080,1,0);
      v(0,0,1,0,1, 'h100,'h40, 5,'h000,0,1);
      v(1,0,1,0,0, 'h100,'h40, 5,'h000,0,1);
      v(0,0,1,1,0, 'h100,'h40, 5,'h000,0,0);
      v(1,0,0,0,0, 'h100,'h40, 5,'h000,0,0);
      v(0,0,0,1,0, 'h100,'h40, 0,'h000,0,0);

      do_reset();
      #1;
      chk("reset_state", int'(state), 0);
      chk("reset_duty", int'(duty), 0);
      chk("reset_runEn", int'(runEn), 0);
      chk("reset_dutyLoad", int'(dutyLoad), 0);

      foreach (tv[i]) begin
         apply(tv[i].st, tv[i].sp, tv[i].f, tv[i].c, tv[i].tk, tv[i].tgt, tv[i].stp);
         chk($sformatf("vec%0d_state", i), int'(state), tv[i].e_state);
         chk($sformatf("vec%0d_duty", i), int'(duty), tv[i].e_duty);
         chk($sformatf("vec%0d_runEn", i), int'(runEn), tv[i].e_run);
         chk($sformatf("vec%0d_dutyLoad", i), int'(dutyLoad), tv[i].e_load);
      end

      // Saturation: ramp to 0xF80 with step 0xFF, then target full scale.
      apply(1,0,0,0,0, 'hF80, 'hFF);
      n = 0;
      do begin
         apply(0,0,0,0,1, 'hF80, 'hFF);
         n++;
      end while (state != 3'd3 && n < 40);
      chk("sat_reach_run", int'(state), 3);
      chk("sat_run_duty", int'(duty), 'hF80);
      apply(0,0,0,0,1, 'hFFF, 'hFF);
      chk("sat_full_duty", int'(duty), 'hFFF);
      chk("sat_full_state", int'(state), 3);
      apply(0,0,0,0,1, 'h800, 'h00);
      chk("step0_down1", int'(duty), 'hFFE);
      apply(0,0,0,0,1, 'h800, 'h00);
      chk("step0_down2", int'(duty), 'hFFD);
      apply(0,0,0,0,1, 'hFFF, 'h00);
      chk("step0_up", int'(duty), 'hFFE);

      // Asynchronous reset in RUN, checked before any further clock edge.
      @(posedge clk);
      #20 nRst = 1'b0;
      #1;
      chk("async_rst_duty", int'(duty), 0);
      chk("async_rst_runEn", int'(runEn), 0);
      chk("async_rst_dutyLoad", int'(dutyLoad), 0);
      chk("async_rst_state", int'(state), 0);

      // Random traffic against the model.
      do_reset();
      f = 0; tgt = 'h100; stp = 'h40;
      for (int k = 0; k < 4000; k++) begin
         if (f) f = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
         else   f = ($urandom_range(0, 99) == 0);
         c  = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 11) == 0);
         sp = ($urandom_range(0, 39) == 0);
         tk = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 49) == 0)
            tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 'h60))
                                              : int'($urandom_range(0, 'hFFF));
         if ($urandom_range(0, 29) == 0)
            stp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 'hFF));
         apply(st, sp, f, c, tk, tgt, stp);
         m_step(st, sp, f, c, tk, tgt, stp);
         chk("rnd_state", int'(state), m_state);
         chk("rnd_duty", int'(duty), m_duty);
         chk("rnd_runEn", int'(runEn), m_run);
         chk("rnd_dutyLoad", int'(dutyLoad), m_load);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
